// File: rtl/speed_calc_writer.sv
// speed_calc_writer: timestamps object IDs at the entry line, then on the matching
// exit-line event divides DIST_K by the elapsed ticks and writes the saturated
// speed into the per-object speed memory with a single-cycle strobe.
module speed_calc_writer #(
  parameter int             WIDTH    = 8,
  parameter int             DEPTH    = 6,
  parameter int             TS_W     = 16,
  parameter int             TICK_DIV = 1000,
  parameter int             K_W      = 24,
  parameter logic [K_W-1:0] DIST_K   = 24'd360000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_entry_vld,
  input  logic [DEPTH-1:0] i_entry_id,
  input  logic             i_exit_vld,
  input  logic [DEPTH-1:0] i_exit_id,
  output logic             o_busy,
  output logic             o_drop,
  output logic             o_wen,
  output logic [DEPTH-1:0] o_addr_speed,
  output logic [WIDTH-1:0] o_speed
);

  localparam int NID   = 1 << DEPTH;
  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;

  state_t             state_q, state_d;
  logic [PS_W-1:0]    ps_q;
  logic [TS_W-1:0]    ts_q;
  logic [NID-1:0]     valid_q;
  logic [TS_W-1:0]    stamp_q [NID];
  logic [CNT_W-1:0]   cnt_q;
  logic [DEPTH-1:0]   id_q;
  logic [K_W-1:0]     num_q;
  logic [K_W-1:0]     rem_q;
  logic [K_W-1:0]     div_q;
  logic [DEPTH-1:0]   addr_q;
  logic [WIDTH-1:0]   speed_q;

  logic               exit_ok;
  logic [TS_W-1:0]    elapsed;
  logic [TS_W-1:0]    elapsed_nz;
  logic [K_W:0]       rem_sh;
  logic [K_W:0]       trial;
  logic [K_W-1:0]     rem_nx;
  logic [K_W-1:0]     num_nx;
  logic               qbit;

  // Quotient bits above the speed word clamp the result to full scale.
  function automatic logic [WIDTH-1:0] sat_speed(input logic [K_W-1:0] q);
    if (|q[K_W-1:WIDTH]) return {WIDTH{1'b1}};
    return q[WIDTH-1:0];
  endfunction

  // Exit qualification, elapsed time, and one restoring-divide step.
  // A zero elapsed count is treated as one tick so the divisor is never zero.
  // The borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    exit_ok    = i_exit_vld && (state_q == IDLE) && valid_q[i_exit_id];
    elapsed    = ts_q - stamp_q[i_exit_id];
    elapsed_nz = (elapsed == '0) ? TS_W'(1) : elapsed;
    rem_sh     = {rem_q, num_q[K_W-1]};
    trial      = rem_sh - {1'b0, div_q};
    qbit       = ~trial[K_W];
    rem_nx     = qbit ? trial[K_W-1:0] : rem_sh[K_W-1:0];
    num_nx     = {num_q[K_W-2:0], qbit};
  end

  // Tick prescaler and free-running timestamp (wraps naturally).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
      ts_q <= '0;
    end else if (ps_q == PS_W'(TICK_DIV - 1)) begin
      ps_q <= '0;
      ts_q <= ts_q + 1'b1;
    end else begin
      ps_q <= ps_q + 1'b1;
    end
  end

  // Valid bits: an accepted exit clears, a same-cycle entry then re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (exit_ok)     valid_q[i_exit_id]  <= 1'b0;
      if (i_entry_vld) valid_q[i_entry_id] <= 1'b1;
    end
  end

  // Entry timestamps; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (i_entry_vld) stamp_q[i_entry_id] <= ts_q;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d = state_q;
    o_busy  = (state_q != IDLE);
    o_wen   = (state_q == WRITE);
    o_drop  = i_exit_vld && !exit_ok;
    case (state_q)
      IDLE:    if (exit_ok) state_d = DIV;
      DIV:     if (cnt_q == '0) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divide step counter: K_W iterations per computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt_q <= '0;
    else if (exit_ok)         cnt_q <= CNT_W'(K_W - 1);
    else if (state_q == DIV)  cnt_q <= cnt_q - 1'b1;
  end

  // Divider datapath: numerator register accumulates the quotient as it shifts.
  always_ff @(posedge clk) begin
    if (exit_ok) begin
      num_q <= DIST_K;
      rem_q <= '0;
      div_q <= K_W'(elapsed_nz);
      id_q  <= i_exit_id;
    end else if (state_q == DIV) begin
      num_q <= num_nx;
      rem_q <= rem_nx;
    end
  end

  // Write address/data load on the last divide step and hold until the next write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      speed_q <= '0;
    end else if ((state_q == DIV) && (cnt_q == '0)) begin
      addr_q  <= id_q;
      speed_q <= sat_speed(num_nx);
    end
  end

  assign o_addr_speed = addr_q;
  assign o_speed      = speed_q;

endmodule

// File: tb/tb_speed_calc_writer.sv
// Scoreboard bench for speed_calc_writer: stimulus drives entry/exit events and
// a table-level model pushes expected writes; a negedge monitor checks outputs.
module tb_speed_calc_writer;

  localparam int             WIDTH    = 8;
  localparam int             DEPTH    = 6;
  localparam int             TS_W     = 10;
  localparam int             TICK_DIV = 4;
  localparam int             K_W      = 24;
  localparam logic [K_W-1:0] DIST_K   = 24'd3600;
  localparam int             NID      = 1 << DEPTH;
  localparam int             TSMOD    = 1 << TS_W;
  localparam int             SMAX     = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             i_entry_vld;
  logic [DEPTH-1:0] i_entry_id;
  logic             i_exit_vld;
  logic [DEPTH-1:0] i_exit_id;
  logic             o_busy;
  logic             o_drop;
  logic             o_wen;
  logic [DEPTH-1:0] o_addr_speed;
  logic [WIDTH-1:0] o_speed;

  speed_calc_writer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .TICK_DIV(TICK_DIV),
    .K_W(K_W), .DIST_K(DIST_K)
  ) dut (
    .clk(clk), .rst(rst),
    .i_entry_vld(i_entry_vld), .i_entry_id(i_entry_id),
    .i_exit_vld(i_exit_vld), .i_exit_id(i_exit_id),
    .o_busy(o_busy), .o_drop(o_drop), .o_wen(o_wen),
    .o_addr_speed(o_addr_speed), .o_speed(o_speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the model derives the timestamp from it.
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int due;
    int addr;
    int speed;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mvalid[NID];
  int   mstamp[NID];
  bit   have_t = 1'b0;
  int   last_t = 0;
  bit   exp_drop = 1'b0;
  int   hold_addr = 0;
  int   hold_speed = 0;

  function automatic int model_ts();
    return (cyc / TICK_DIV) % TSMOD;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs with the model every cycle, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (rst) begin
      check("reset_outputs", int'({o_wen, o_busy, o_drop, o_addr_speed, o_speed}), 0);
    end else begin
      exp_busy = have_t && (cyc >= last_t + 1) && (cyc <= last_t + K_W + 1);
      check("busy", int'(o_busy), int'(exp_busy));
      check("drop", int'(o_drop), int'(exp_drop));
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL wen_missing: no write seen, required at cycle %0d addr %0d speed %0d", e.due, e.addr, e.speed);
      end
      if (o_wen) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wen_unexpected: write addr %0d speed %0d at cycle %0d, none required", o_addr_speed, o_speed, cyc);
        end else begin
          e = sbq.pop_front();
          check("wen_cycle", cyc, e.due);
          hold_addr  = e.addr;
          hold_speed = e.speed;
        end
      end
      check("addr", int'(o_addr_speed), hold_addr);
      check("speed", int'(o_speed), hold_speed);
    end
  end

  // One cycle of stimulus; the model decides the outcome from table-level rules.
  task automatic step(input bit ev, input int eid, input bit xv, input int xid);
    int ts, el, q;
    bit idle;
    ts   = model_ts();
    idle = !have_t || (cyc > last_t + K_W + 1);
    exp_drop = 1'b0;
    if (xv) begin
      if (idle && mvalid[xid]) begin
        el = (ts - mstamp[xid] + TSMOD) % TSMOD;
        if (el == 0) el = 1;
        q = int'(DIST_K) / el;
        sbq.push_back('{cyc + K_W + 1, xid, (q > SMAX) ? SMAX : q});
        last_t = cyc;
        have_t = 1'b1;
        mvalid[xid] = 1'b0;
      end else begin
        exp_drop = 1'b1;
      end
    end
    if (ev) begin
      mstamp[eid] = ts;
      mvalid[eid] = 1'b1;
    end
    i_entry_vld = ev;
    i_entry_id  = eid[DEPTH-1:0];
    i_exit_vld  = xv;
    i_exit_id   = xid[DEPTH-1:0];
    @(posedge clk);
    #1;
    i_entry_vld = 1'b0;
    i_exit_vld  = 1'b0;
    exp_drop    = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic wait_idle();
    idle_n(K_W + 3);
  endtask

  task automatic wait_ts(input int t);
    int n;
    n = 0;
    while (model_ts() != t && n < 8192) begin
      step(1'b0, 0, 1'b0, 0);
      n++;
    end
    if (model_ts() != t) begin
      checks++;
      errors++;
      $display("FAIL wait_ts: timestamp %0d, required %0d", model_ts(), t);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sbq.delete();
    for (int i = 0; i < NID; i++) mvalid[i] = 1'b0;
    have_t     = 1'b0;
    hold_addr  = 0;
    hold_speed = 0;
    exp_drop   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_entry_vld = 1'b0;
    i_entry_id  = '0;
    i_exit_vld  = 1'b0;
    i_exit_id   = '0;
    #1;
    do_reset(3);

    // Entry id3 at ts 0; later exit at ts 10 saturates (360 -> 255).
    step(1'b1, 3, 1'b0, 0);
    wait_ts(10);
    step(1'b1, 5, 1'b1, 3);
    wait_idle();
    // Exit id5 at ts 110 after entry at ts 10: 3600/100 = 36.
    wait_ts(110);
    step(1'b0, 0, 1'b1, 5);
    wait_idle();

    // Exit without a prior entry.
    step(1'b0, 0, 1'b1, 7);
    idle_n(2);

    // Second exit while busy is dropped, its entry kept for a later exit.
    step(1'b1, 1, 1'b0, 0);
    step(1'b1, 2, 1'b0, 0);
    idle_n(40);
    step(1'b0, 0, 1'b1, 1);
    idle_n(5);
    step(1'b0, 0, 1'b1, 2);
    wait_idle();
    step(1'b0, 0, 1'b1, 2);
    wait_idle();

    // Same-cycle entry and exit on one id: exit uses old stamp, entry re-arms.
    step(1'b1, 9, 1'b0, 0);
    idle_n(60);
    step(1'b1, 9, 1'b1, 9);
    wait_idle();
    idle_n(8);
    step(1'b0, 0, 1'b1, 9);
    wait_idle();

    // Exit arriving in the WRITE cycle is dropped.
    step(1'b1, 10, 1'b0, 0);
    step(1'b1, 11, 1'b0, 0);
    idle_n(4);
    step(1'b0, 0, 1'b1, 10);
    idle_n(K_W);
    step(1'b0, 0, 1'b1, 11);
    wait_idle();

    // Timestamp wrap: entry at 0x3F0, exit at 0x040 -> elapsed 80, speed 45.
    wait_ts(10'h3F0);
    step(1'b1, 4, 1'b0, 0);
    wait_ts(10'h040);
    step(1'b0, 0, 1'b1, 4);
    wait_idle();

    // Reset in the middle of a divide aborts the write and clears the table.
    step(1'b1, 6, 1'b0, 0);
    idle_n(5);
    step(1'b0, 0, 1'b1, 6);
    idle_n(6);
    do_reset(2);
    step(1'b0, 0, 1'b1, 6);
    wait_idle();

    // Randomized traffic over a small ID range so entries and exits collide.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 10), int'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 6),  int'($urandom_range(0, 7)));
    end
    wait_idle();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes still pending, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
